if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- IF-stage producer for the IF/ID pipeline register. Generates the PC, addresses the combinational instruction ROM, and forwards Instr, PC and PC+4 toward IF/ID.
- Predicts the next PC using static decode of j/jal and a 2-bit bimodal branch history table (BHT). Emits PredictJump alongside each fetched instruction.
- Accepts EX-stage redirects on mispredict and BHT training updates. Honours the hazard unit's stall.

Parameters:
- RESET_PC, 32'h0000_3000: PC value loaded on reset.
- BHT_BITS, 6: log2 of the number of BHT entries (64 two-bit counters).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- CLR  in  1  asynchronous, active-high reset.
- Stall  in  1  1 = hold PC this cycle; BHT updates still apply.
- Redirect  in  1  EX-stage mispredict or jr; PC is loaded from Redirect_PC.
- Redirect_PC  in  32  correct next PC.
- Update_Valid  in  1  resolved conditional branch in EX; trains the BHT.
- Update_PC  in  32  PC of the resolved branch.
- Update_Taken  in  1  actual branch outcome.
- IMem_Data  in  32  instruction word read at IMem_Addr (combinational ROM).
- IMem_Addr  out  32  equals PC.
- Instr  out  32  equals IMem_Data; to IF/ID.
- PC  out  32  current fetch PC; to IF/ID.
- PC_plus_four  out  32  PC+4; to IF/ID.
- PredictJump  out  1  prediction made for this Instr; to IF/ID.
- IF_Flush  out  1  equals Redirect; drives the IF/ID clear so the wrong-path word becomes a bubble.

Behaviour:
- Reset: asynchronous, active-high, on CLR.
  - PC = RESET_PC.
  - All BHT counters = 2'b01 (weakly not-taken).
  - Outputs follow combinationally from the reset state: IMem_Addr = PC = RESET_PC, PC_plus_four = RESET_PC+4, PredictJump per decode of IMem_Data, IF_Flush = Redirect.
- Arithmetic: PC_plus_four = PC + 32'd4, wraps modulo 2^32.
- Decode of IMem_Data, opcode = [31:26]:
  - Conditional branches: 000100 beq, 000101 bne, 000110 blez, 000111 bgtz, 000001 regimm. Target = PC_plus_four + (sign-extended [15:0] << 2), truncated to 32 bits.
  - Unconditional: 000010 j, 000011 jal. Target = {PC_plus_four[31:28], [25:0], 2'b00}.
  - jr/jalr and all other opcodes are never predicted.
- PredictJump = uncond | (cond & BHT[PC[BHT_BITS+1:2]][1]). It is combinational and zero-latency, valid in the same cycle as Instr.
- Next-PC priority, highest first:
  1. Redirect → {Redirect_PC[31:2], 2'b00}. Applies even if Stall = 1.
  2. Stall → hold PC.
  3. PredictJump → target.
  4. Otherwise → PC_plus_four.
- BHT update: when Update_Valid = 1, entry Update_PC[BHT_BITS+1:2] is incremented if Update_Taken, else decremented, saturating at 0 and 3.
  - The update applies regardless of Stall and Redirect.
- Same-cycle read/write to the same entry: the prediction uses the old value; the new value is visible next cycle.
- Fetch latency: one cycle per instruction. A predicted-taken branch costs no bubble. A redirect costs the wrong-path fetch, which is cleared via IF_Flush.
- Unaligned PC: never produced internally. Redirect_PC bits [1:0] are forced to 0.

Decomposition:
- Shared package:
  - Opcode constants OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM, OP_J, OP_JAL.
  - BHT counter encodings SNT=0, WNT=1, WT=2, ST=3.
  - RESET_PC default.
- One sub-module, bht_2bit: BHT_BITS-indexed counter array.
  - One combinational read port.
  - One synchronous saturating-update port.
  - Asynchronous CLR to WNT.

Test Plan:
- Reset then release with IMem_Data = 0 (nop): PC sequence is 0x3000, 0x3004, 0x3008; PredictJump = 0; IF_Flush = 0.
- At PC 0x3008, IMem_Data = 0x08000C10 (j 0x3040): PredictJump = 1 that cycle; next PC = 0x3040.
- beq with imm = 0xFFFF at PC 0x3010, with a fresh BHT: PredictJump = 0; next PC = 0x3014. Then drive Update_Valid = 1 and Update_Taken = 1 with Update_PC = 0x3010, twice. Refetch 0x3010: PredictJump = 1; next PC = 0x3010.
- Stall = 1 held for 3 cycles at PC 0x3020: PC stays at 0x3020. Redirect = 1 with Redirect_PC = 0x3103 in the second stall cycle: next PC = 0x3100 and IF_Flush = 1 in that cycle.
- BHT saturation: 5 not-taken updates on one entry leave it at 0. Then 1 taken update gives 1, and PredictJump remains 0.
- Assert CLR asynchronously mid-cycle while PC = 0x3100: PC becomes 0x3000 immediately, without waiting for CLK; a previously trained entry reads 01 again.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants for the IF-stage fetch unit: MIPS opcodes, BHT counter states, reset PC.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int unsigned BHT_BITS_DEFAULT = 6;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bht_ctr_e;

endpackage

// File: rtl/bht_2bit.sv
// Bimodal branch history table: 2^BHT_BITS saturating 2-bit counters,
// one combinational read port and one synchronous update port.
module bht_2bit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned BHT_BITS = BHT_BITS_DEFAULT
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic [BHT_BITS-1:0] rd_idx_i,
    output logic [1:0]          rd_ctr_o,
    input  logic                upd_en_i,
    input  logic [BHT_BITS-1:0] upd_idx_i,
    input  logic                upd_taken_i
);

    localparam int unsigned ENTRIES = 1 << BHT_BITS;

    logic [ENTRIES-1:0][1:0] ctr_q;
    logic [1:0]              upd_cur;
    logic [1:0]              upd_nxt;

    // Reads see the pre-update value when read and write hit the same entry.
    assign rd_ctr_o = ctr_q[rd_idx_i];
    assign upd_cur  = ctr_q[upd_idx_i];

    always_comb begin
        upd_nxt = upd_cur;
        if (upd_taken_i) begin
            if (upd_cur != ST) upd_nxt = upd_cur + 2'd1;
        end else begin
            if (upd_cur != SNT) upd_nxt = upd_cur - 2'd1;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            ctr_q <= {ENTRIES{2'(WNT)}};
        end else if (upd_en_i) begin
            ctr_q[upd_idx_i] <= upd_nxt;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage PC generator with static j/jal decode and bimodal prediction of
// conditional branches; EX redirects override everything including stall.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned BHT_BITS = BHT_BITS_DEFAULT
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    input  logic        Update_Valid,
    input  logic [31:0] Update_PC,
    input  logic        Update_Taken,
    input  logic [31:0] IMem_Data,
    output logic [31:0] IMem_Addr,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PC_plus_four,
    output logic        PredictJump,
    output logic        IF_Flush
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic        is_cond;
    logic        is_uncond;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] pred_target;
    logic [1:0]  bht_ctr;
    logic        predict;
    logic        unused_bits;

    assign pc_plus4 = pc_q + 32'd4;
    assign opcode   = IMem_Data[31:26];

    always_comb begin
        is_cond   = 1'b0;
        is_uncond = 1'b0;
        case (opcode)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: is_cond   = 1'b1;
            OP_J, OP_JAL:                                is_uncond = 1'b1;
            default: ;
        endcase
    end

    assign br_target   = pc_plus4 + {{14{IMem_Data[15]}}, IMem_Data[15:0], 2'b00};
    assign j_target    = {pc_plus4[31:28], IMem_Data[25:0], 2'b00};
    assign pred_target = is_uncond ? j_target : br_target;

    bht_2bit #(
        .BHT_BITS(BHT_BITS)
    ) u_bht (
        .CLK         (CLK),
        .CLR         (CLR),
        .rd_idx_i    (pc_q[BHT_BITS+1:2]),
        .rd_ctr_o    (bht_ctr),
        .upd_en_i    (Update_Valid),
        .upd_idx_i   (Update_PC[BHT_BITS+1:2]),
        .upd_taken_i (Update_Taken)
    );

    assign predict = is_uncond | (is_cond & bht_ctr[1]);

    // Next-PC priority: redirect, stall, prediction, sequential.
    always_comb begin
        pc_d = pc_plus4;
        if (Redirect)     pc_d = {Redirect_PC[31:2], 2'b00};
        else if (Stall)   pc_d = pc_q;
        else if (predict) pc_d = pred_target;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign IMem_Addr    = pc_q;
    assign PC           = pc_q;
    assign PC_plus_four = pc_plus4;
    assign Instr        = IMem_Data;
    assign PredictJump  = predict;
    assign IF_Flush     = Redirect;

    assign unused_bits = ^{Redirect_PC[1:0], Update_PC[31:BHT_BITS+2], Update_PC[1:0]};

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed vector bench for if_fetch_unit: per-cycle table plus async-reset sequence.
module tb_if_fetch_unit;

    logic        clk;
    logic        clr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus_four;
    logic        predict_jump;
    logic        if_flush;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] J40 = 32'h0800_0C10;  // j 0x3040
    localparam logic [31:0] BEQ = 32'h1000_FFFF;  // beq imm=-1
    localparam logic [31:0] JAL = 32'h0C00_0010;  // jal, low target 0x40
    localparam logic [31:0] BNE = 32'h1400_0001;  // bne imm=+1

    if_fetch_unit dut (
        .CLK          (clk),
        .CLR          (clr),
        .Stall        (stall),
        .Redirect     (redirect),
        .Redirect_PC  (redirect_pc),
        .Update_Valid (upd_valid),
        .Update_PC    (upd_pc),
        .Update_Taken (upd_taken),
        .IMem_Data    (imem_data),
        .IMem_Addr    (imem_addr),
        .Instr        (instr),
        .PC           (pc),
        .PC_plus_four (pc_plus_four),
        .PredictJump  (predict_jump),
        .IF_Flush     (if_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] imem;
        logic [31:0] e_pc;
        logic [31:0] e_pp4;
        logic        e_pj;
        logic        e_fl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic r, logic [31:0] rp, logic uv, logic [31:0] up,
                                logic ut, logic [31:0] im, logic [31:0] epc, logic [31:0] epp4,
                                logic epj, logic efl);
        vec_t v;
        v.stall = s;  v.redir = r;   v.rpc = rp;
        v.uv = uv;    v.upc = up;    v.ut = ut;   v.imem = im;
        v.e_pc = epc; v.e_pp4 = epp4; v.e_pj = epj; v.e_fl = efl;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall = v.stall;  redirect = v.redir; redirect_pc = v.rpc;
        upd_valid = v.uv; upd_pc = v.upc;     upd_taken = v.ut;
        imem_data = v.imem;
    endtask

    initial begin
        clr = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; imem_data = NOP;

        // s  r  rpc           uv upc           ut imem  pc            pc+4          pj fl
        vecs.push_back(mk(0,0,32'h0,        0,32'h0,   0,NOP,32'h0000_3000,32'h0000_3004,0,0));
        vecs.push_back(mk(0,0,32'h0,        0,32'h0,   0,NOP,32'h0000_3004,32'h0000_3008,0,0));
        vecs.push_back(mk(0,0,32'h0,        0,32'h0,   0,J40,32'h0000_3008,32'h0000_300C,1,0));
        vecs.push_back(mk(0,1,32'h0000_3010,0,32'h0,   0,NOP,32'h0000_3040,32'h0000_3044,0,1));
        vecs.push_back(mk(0,0,32'h0,        1,32'h3010,1,BEQ,32'h0000_3010,32'h0000_3014,0,0));
        vecs.push_back(mk(0,0,32'h0,        1,32'h3010,1,NOP,32'h0000_3014,32'h0000_3018,0,0));
        vecs.push_back(mk(0,1,32'h0000_3010,0,32'h0,   0,NOP,32'h0000_3018,32'h0000_301C,0,1));
        vecs.push_back(mk(0,0,32'h0,        0,32'h0,   0,BEQ,32'h0000_3010,32'h0000_3014,1,0));
        vecs.push_back(mk(0,1,32'h0000_3020,0,32'h0,   0,BEQ,32'h0000_3010,32'h0000_3014,1,1));
        vecs.push_back(mk(1,0,32'h0,        0,32'h0,   0,NOP,32'h0000_3020,32'h0000_3024,0,0));
        vecs.push_back(mk(1,1,32'h0000_3103,0,32'h0,   0,NOP,32'h0000_3020,32'h0000_3024,0,1));
        vecs.push_back(mk(1,0,32'h0,        0,32'h0,   0,NOP,32'h0000_3100,32'h0000_3104,0,0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1,0,32'h0,    1,32'h3100,0,BEQ,32'h0000_3100,32'h0000_3104,0,0));
        vecs.push_back(mk(1,0,32'h0,        1,32'h3100,1,BEQ,32'h0000_3100,32'h0000_3104,0,0));
        vecs.push_back(mk(1,0,32'h0,        0,32'h0,   0,BEQ,32'h0000_3100,32'h0000_3104,0,0));
        vecs.push_back(mk(1,0,32'h0,        1,32'h3100,1,BEQ,32'h0000_3100,32'h0000_3104,0,0));
        vecs.push_back(mk(1,0,32'h0,        0,32'h0,   0,BEQ,32'h0000_3100,32'h0000_3104,1,0));
        vecs.push_back(mk(0,1,32'h1FFF_FFFC,0,32'h0,   0,NOP,32'h0000_3100,32'h0000_3104,0,1));
        vecs.push_back(mk(0,0,32'h0,        0,32'h0,   0,JAL,32'h1FFF_FFFC,32'h2000_0000,1,0));
        vecs.push_back(mk(0,1,32'hFFFF_FFFE,0,32'h0,   0,NOP,32'h2000_0040,32'h2000_0044,0,1));
        vecs.push_back(mk(0,0,32'h0,        0,32'h0,   0,BNE,32'hFFFF_FFFC,32'h0000_0000,0,0));
        vecs.push_back(mk(0,1,32'h0000_3100,0,32'h0,   0,NOP,32'h0000_0000,32'h0000_0004,0,1));
        vecs.push_back(mk(1,0,32'h0,        0,32'h0,   0,NOP,32'h0000_3100,32'h0000_3104,0,0));

        // Reset asserted away from any clock edge.
        #1 clr = 1'b1;
        #1;
        check32("reset_pc",    pc, 32'h0000_3000);
        check32("reset_addr",  imem_addr, 32'h0000_3000);
        check32("reset_pp4",   pc_plus_four, 32'h0000_3004);
        check32("reset_pj",    32'(predict_jump), 32'd0);
        check32("reset_flush", 32'(if_flush), 32'd0);
        @(posedge clk); #2;
        clr = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            check32($sformatf("v%0d_pc", i),    pc, vecs[i].e_pc);
            check32($sformatf("v%0d_addr", i),  imem_addr, vecs[i].e_pc);
            check32($sformatf("v%0d_pp4", i),   pc_plus_four, vecs[i].e_pp4);
            check32($sformatf("v%0d_instr", i), instr, vecs[i].imem);
            check32($sformatf("v%0d_pj", i),    32'(predict_jump), 32'(vecs[i].e_pj));
            check32($sformatf("v%0d_flush", i), 32'(if_flush), 32'(vecs[i].e_fl));
            @(posedge clk); #1;
        end

        // Mid-cycle async reset at PC 0x3100 while stalled.
        check32("pre_clr_pc", pc, 32'h0000_3100);
        #2 clr = 1'b1;
        #1;
        check32("async_clr_pc",  pc, 32'h0000_3000);
        check32("async_clr_pp4", pc_plus_four, 32'h0000_3004);
        #1 clr = 1'b0;
        stall = 1'b0; upd_valid = 1'b0; redirect = 1'b0; imem_data = BEQ;
        @(negedge clk);
        check32("post_clr_entry0_pj", 32'(predict_jump), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_3010; imem_data = NOP;
        @(posedge clk); #1;
        redirect = 1'b0; imem_data = BEQ;
        @(negedge clk);
        check32("post_clr_pc",        pc, 32'h0000_3010);
        check32("post_clr_entry4_pj", 32'(predict_jump), 32'd0);
        @(posedge clk); #1;
        check32("post_clr_next_pc",   pc, 32'h0000_3014);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
